// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings.
// The master side is the sequencer itself; the slave side is the PLL/consumer view.
// Optional macro PLL_SEQ_LOSS_CNT_EN adds the saturating loss_count bus.
interface pll_lock_sequencer_if;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       rst_out_n;
  logic       ready;
  logic       fault;
  logic       lock_lost;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_count;
`endif

  modport master (
    input  locked,
    input  restart,
    output pll_resetb,
    output rst_out_n,
    output ready,
    output fault,
`ifdef PLL_SEQ_LOSS_CNT_EN
    output loss_count,
`endif
    output lock_lost
  );

  modport slave (
    output locked,
    output restart,
    input  pll_resetb,
    input  rst_out_n,
    input  ready,
    input  fault,
`ifdef PLL_SEQ_LOSS_CNT_EN
    input  loss_count,
`endif
    input  lock_lost
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / recovery sequencer running on the raw board clock.
// Pulses PLL RESETB, waits for a filtered lock, holds it stable, then releases
// rst_out_n/ready. Lock loss re-sequences the PLL; exhausted retries park in FAULT.
// Optional macro PLL_SEQ_LOSS_CNT_EN adds an 8-bit saturating lock-loss counter.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 16
) (
  input logic                  clock_in,
  input logic                  reset_n,
  pll_lock_sequencer_if.master seq_if
);

  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0]  RstLast     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  StableLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StPllReset,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              sync1_q, sync1_d;
  logic              lock_s_q, lock_s_d;
  logic              lock_lost_q, lock_lost_d;

  // Lock synchroniser; held clear while the PLL is in reset so a stale lock
  // flag cannot carry over into the next WAIT_LOCK window.
  always_comb begin
    sync1_d  = seq_if.locked;
    lock_s_d = sync1_q;
    if (state_q == StPllReset) begin
      sync1_d  = 1'b0;
      lock_s_d = 1'b0;
    end
  end

  // Next-state, shared counter and retry bookkeeping; restart overrides all.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    unique case (state_q)
      StPllReset: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWaitLock: begin
        if (lock_s_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d = '0;
          if (retry_q == RetryMax) begin
            state_d = StFault;
          end else begin
            retry_d = retry_q + RetryW'(1);
            state_d = StPllReset;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStable: begin
        // A lock dropout restarts the timeout window but spends no retry.
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRun: begin
        retry_d = '0;
        if (!lock_s_q) begin
          state_d     = StPllReset;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end
      end
      StFault: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StPllReset;
        cnt_d   = '0;
      end
    endcase

    if (seq_if.restart) begin
      state_d     = StPllReset;
      cnt_d       = '0;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StPllReset;
      cnt_q       <= '0;
      retry_q     <= '0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync1_q     <= sync1_d;
      lock_s_q    <= lock_s_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Outputs come from registered state only.
  assign seq_if.pll_resetb = !((state_q == StPllReset) || (state_q == StFault));
  assign seq_if.rst_out_n  = (state_q == StRun);
  assign seq_if.ready      = (state_q == StRun);
  assign seq_if.fault      = (state_q == StFault);
  assign seq_if.lock_lost  = lock_lost_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Saturating count of lock-loss events; only reset_n clears it.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_lost_d && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  // Loss counter register.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign seq_if.loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer.
// Uses RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2.
// Loss-counter checks are compiled in when PLL_SEQ_LOSS_CNT_EN is defined.
module tb_pll_lock_sequencer;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .CNT_W         (16)
  ) dut (
    .clock_in (clk),
    .reset_n  (reset_n),
    .seq_if   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse; returns just after release, before edge 1 of the sequence.
  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.restart = 1'b0;
    reset_n     = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.locked  = 1'b0;
    bus.restart = 1'b0;
    reset_n     = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.pll_resetb !== 1'b0) begin
        errors++;
        $display("FAIL reset_pll_resetb pass=%0d got=%b exp=0", k, bus.pll_resetb);
      end
      checks++;
      if (bus.rst_out_n !== 1'b0 || bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready pass=%0d got rst_out_n=%b ready=%b exp=0", k, bus.rst_out_n,
                 bus.ready);
      end
      checks++;
      if (bus.fault !== 1'b0 || bus.lock_lost !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags pass=%0d got fault=%b lock_lost=%b exp=0", k, bus.fault,
                 bus.lock_lost);
      end
`ifdef PLL_SEQ_LOSS_CNT_EN
      checks++;
      if (bus.loss_count !== 8'd0) begin
        errors++;
        $display("FAIL reset_loss_count got=%0d exp=0", bus.loss_count);
      end
`endif
      step();
    end
  endtask

  task automatic test_power_up();
    bus.locked = 1'b1;
    do_reset();
    for (int e = 0; e <= 16; e++) begin
      if (e > 0) step();
      checks++;
      if (bus.pll_resetb !== (e >= 4)) begin
        errors++;
        $display("FAIL pwr_pll_resetb edge=%0d got=%b exp=%b", e, bus.pll_resetb, e >= 4);
      end
      checks++;
      if (bus.ready !== (e >= 15) || bus.rst_out_n !== (e >= 15)) begin
        errors++;
        $display("FAIL pwr_ready edge=%0d got ready=%b rst_out_n=%b exp=%b", e, bus.ready,
                 bus.rst_out_n, e >= 15);
      end
      checks++;
      if (bus.fault !== 1'b0 || bus.lock_lost !== 1'b0) begin
        errors++;
        $display("FAIL pwr_flags edge=%0d got fault=%b lock_lost=%b exp=0", e, bus.fault,
                 bus.lock_lost);
      end
    end
  endtask

  task automatic test_stable_glitch();
    bus.locked = 1'b1;
    do_reset();
    for (int e = 1; e <= 26; e++) begin
      step();
      // Drop lock for the single cycle after edge 12 (STABLE counter = 5).
      bus.locked = (e == 12) ? 1'b0 : 1'b1;
      checks++;
      if (bus.ready !== (e >= 24)) begin
        errors++;
        $display("FAIL glitch_ready edge=%0d got=%b exp=%b", e, bus.ready, e >= 24);
      end
      checks++;
      if (bus.pll_resetb !== (e >= 4)) begin
        errors++;
        $display("FAIL glitch_pll_resetb edge=%0d got=%b exp=%b", e, bus.pll_resetb, e >= 4);
      end
    end
  endtask

  // Runs straight after test_stable_glitch, which leaves the DUT in RUN.
  task automatic test_lock_loss();
    bus.locked = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      step();
      checks++;
      if (bus.ready !== (r < 3) || bus.rst_out_n !== (r < 3)) begin
        errors++;
        $display("FAIL loss_ready r=%0d got ready=%b rst_out_n=%b exp=%b", r, bus.ready,
                 bus.rst_out_n, r < 3);
      end
      checks++;
      if (bus.lock_lost !== (r == 3)) begin
        errors++;
        $display("FAIL loss_pulse r=%0d got=%b exp=%b", r, bus.lock_lost, r == 3);
      end
      checks++;
      if (bus.pll_resetb !== !(r >= 3 && r <= 6)) begin
        errors++;
        $display("FAIL loss_pll_resetb r=%0d got=%b exp=%b", r, bus.pll_resetb,
                 !(r >= 3 && r <= 6));
      end
`ifdef PLL_SEQ_LOSS_CNT_EN
      checks++;
      if (bus.loss_count !== ((r >= 3) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL loss_count r=%0d got=%0d exp=%0d", r, bus.loss_count, (r >= 3) ? 1 : 0);
      end
`endif
    end
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    checks++;
    if (bus.lock_lost !== 1'b0 || bus.pll_resetb !== 1'b0) begin
      errors++;
      $display("FAIL loss_restart got lock_lost=%b pll_resetb=%b exp 0/0", bus.lock_lost,
               bus.pll_resetb);
    end
`ifdef PLL_SEQ_LOSS_CNT_EN
    checks++;
    if (bus.loss_count !== 8'd1) begin
      errors++;
      $display("FAIL loss_count_restart got=%0d exp=1", bus.loss_count);
    end
`endif
  endtask

  // Checks the 3-attempt retry budget from a freshly started sequence.
  task automatic check_fault_timing(input string tag);
    for (int e = 0; e <= 320; e++) begin
      if (e > 0) step();
      checks++;
      if (bus.fault !== (e >= 312)) begin
        errors++;
        $display("FAIL %s_fault edge=%0d got=%b exp=%b", tag, e, bus.fault, e >= 312);
      end
      checks++;
      if (bus.pll_resetb !== ((e < 312) && ((e % 104) >= 4))) begin
        errors++;
        $display("FAIL %s_pll_resetb edge=%0d got=%b exp=%b", tag, e, bus.pll_resetb,
                 (e < 312) && ((e % 104) >= 4));
      end
      checks++;
      if (bus.ready !== 1'b0 || bus.rst_out_n !== 1'b0) begin
        errors++;
        $display("FAIL %s_ready edge=%0d got ready=%b rst_out_n=%b exp=0", tag, e, bus.ready,
                 bus.rst_out_n);
      end
    end
  endtask

  task automatic test_fault();
    bus.locked = 1'b0;
    do_reset();
    check_fault_timing("fault");
  endtask

  // Runs straight after test_fault, which leaves the DUT in FAULT.
  task automatic test_restart();
    bus.locked  = 1'b0;
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    checks++;
    if (bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL restart_fault_clear got=%b exp=0", bus.fault);
    end
    check_fault_timing("restart");
  endtask

  task automatic test_async_reset();
    bus.locked = 1'b1;
    do_reset();
    repeat (15) step();
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_run got ready=%b exp=1", bus.ready);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.rst_out_n !== 1'b0 || bus.pll_resetb !== 1'b0) begin
      errors++;
      $display("FAIL async_drop got ready=%b rst_out_n=%b pll_resetb=%b exp 0/0/0", bus.ready,
               bus.rst_out_n, bus.pll_resetb);
    end
    #1;
    reset_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      checks++;
      if (bus.pll_resetb !== (e >= 4) || bus.ready !== (e >= 15)) begin
        errors++;
        $display("FAIL async_resequence edge=%0d got pll_resetb=%b ready=%b exp %b/%b", e,
                 bus.pll_resetb, bus.ready, e >= 4, e >= 15);
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b1;
    bus.locked  = 1'b0;
    bus.restart = 1'b0;
    test_reset();
    test_power_up();
    test_stable_glitch();
    test_lock_loss();
    test_fault();
    test_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
